grid_canvas: RTL and testbench
==============================

Name: grid_canvas

Overview:
- Parametrised successor to the fixed mouse-to-cell snapping and drawing path of the digit-input front end.
- Maps a bounded mouse position to a cell of a COLS x ROWS drawing grid.
- Paints or erases that whole cell on the VGA adapter, one pixel per cycle, and keeps a per-cell occupancy bitmap that the neural-network input stage reads.
- Adds erase, clear-all, duplicate suppression and bitmap readout, which the fixed-size path lacks.

Parameters:
- X0, 88, left pixel column of the grid region
- Y0, 37, top pixel row of the grid region
- CELL_W, 10, cell width in pixels (>=2)
- CELL_H, 13, cell height in pixels (>=2)
- COLS, 14, grid columns
- ROWS, 14, grid rows
- COLOR_BITS, 15, VGA colour width
- FG_COLOR, 15'h7FFF, paint colour
- BG_COLOR, 15'h0000, erase/clear colour

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mouse_x  in  9  pointer x, pixel units
- mouse_y  in  9  pointer y, pixel units
- paint  in  1  level request: fill the cell under the pointer
- erase  in  1  level request: blank the cell under the pointer
- clear_all  in  1  level request: blank the whole grid
- busy  out  1  high whenever the block is not in IDLE
- done  out  1  one-cycle pulse when an accepted operation completes
- vga_x  out  9  plot x
- vga_y  out  9  plot y
- vga_color  out  COLOR_BITS  plot colour
- vga_plot  out  1  write strobe to the VGA adapter
- cell_rd_addr  in  $clog2(COLS*ROWS)  bitmap index, row*COLS+col
- cell_rd_data  out  1  combinational read of the bitmap bit

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All bitmap bits go to 0.
  - busy, done, vga_plot go to 0; vga_x, vga_y, vga_color go to 0.
  - Reset mid-operation aborts immediately; no further plots.
- States: IDLE, LOCATE, FILL, CLEAR, FINISH.
- IDLE:
  - Requests are sampled only in IDLE; requests raised while busy are ignored.
  - Priority is clear_all > erase > paint.
  - clear_all goes to CLEAR.
  - paint or erase goes to LOCATE only if X0 <= mouse_x < X0+COLS*CELL_W and Y0 <= mouse_y < Y0+ROWS*CELL_H. The coordinates and the request type are latched.
  - Out-of-region requests are ignored: no busy, no done.
- LOCATE:
  - Computes col and row by iterative subtraction of CELL_W and CELL_H, one step per cycle, both axes in parallel.
  - Latency is at most max(COLS,ROWS)+1 cycles.
  - If the bitmap bit already equals the target value (1 for paint, 0 for erase), go to FINISH with no plots.
  - Otherwise go to FILL.
- FILL:
  - Plots exactly CELL_W*CELL_H pixels, one per cycle, with vga_plot=1 on each.
  - Order is raster: x inner loop, y outer loop, starting at (X0+col*CELL_W, Y0+row*CELL_H).
  - Colour is FG_COLOR for paint and BG_COLOR for erase.
  - The bitmap bit is written on the last plot cycle.
- CLEAR:
  - Plots the full region, COLS*CELL_W*ROWS*CELL_H pixels, in raster order with BG_COLOR.
  - All bitmap bits go to 0 on the last plot cycle.
- FINISH: done=1 for one cycle, then IDLE. The updated bitmap is visible on cell_rd_data during FINISH.
- Outputs are registered. vga_plot is never high outside FILL and CLEAR.
- Pixel counters wrap only at their cell or region bounds; there is no partial-cell plotting.

Optional Feature:
- Macro: GRID_CANVAS_GAP_EN.
- When defined, FILL plots the last pixel column and last pixel row of each cell in BG_COLOR regardless of the operation, giving visible grid lines. The plot count is unchanged.
- When undefined, the whole cell uses the operation colour.

Decomposition:
- Package grid_canvas_pkg holds:
  - the state enumeration
  - default geometry constants (X0, Y0, CELL_W, CELL_H, COLS, ROWS)
  - the default FG_COLOR and BG_COLOR
- One sub-module, cell_locator: the iterative subtract divider. It takes a start pulse and the offset coordinates, and returns col, row and a valid flag.

Test Plan:
- paint=1 at (88,37) → 130 plots, x 88..97, y 37..49, colour 7FFF; bit 0 = 1; one done pulse.
- Repeat paint at (95,40) after the above → zero plots; done pulses once; bit 0 stays 1.
- paint at (227,218) → cell 195, x 218..227, y 206..218; erase at the same point → 130 BG plots; bit 195 = 0.
- paint at (87,37) and at (88,219) → no busy, no plot, no done.
- clear_all and paint raised together with several bits set → 25480 BG plots; all bits 0; one done.
- Assert reset after the 50th plot of a FILL → vga_plot=0 asynchronously; busy=0; all bits 0. A following paint works normally.

Source files
------------

// File: rtl/grid_canvas_pkg.sv
// Shared types and default geometry for the grid drawing canvas.
// Holds the controller state encoding plus the default grid placement and colours.
// No logic lives here; the top and the locator import it.
package grid_canvas_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOCATE = 3'd1,
        S_FILL   = 3'd2,
        S_CLEAR  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam int DEF_X0         = 88;
    localparam int DEF_Y0         = 37;
    localparam int DEF_CELL_W     = 10;
    localparam int DEF_CELL_H     = 13;
    localparam int DEF_COLS       = 14;
    localparam int DEF_ROWS       = 14;
    localparam int DEF_COLOR_BITS = 15;

    localparam logic [14:0] DEF_FG_COLOR = 15'h7FFF;
    localparam logic [14:0] DEF_BG_COLOR = 15'h0000;

endpackage

// File: rtl/cell_locator.sv
// Converts a pixel offset inside the grid into (col,row) by repeated subtraction.
// Latency: o_valid rises max(col,row) cycles after i_start (same cycle if both are 0).
// No backpressure: o_valid stays high until the next i_start or reset.
module cell_locator
    import grid_canvas_pkg::*;
#(
    parameter int CELL_W = DEF_CELL_W,
    parameter int CELL_H = DEF_CELL_H,
    parameter int CW     = 4,
    parameter int RW     = 4
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [8:0]    i_off_x,
    input  logic [8:0]    i_off_y,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_valid
);

    localparam logic [8:0] STEP_X = 9'(CELL_W);
    localparam logic [8:0] STEP_Y = 9'(CELL_H);

    logic [8:0]    r_rem_x;
    logic [8:0]    r_rem_y;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_busy;
    logic          w_x_more;
    logic          w_y_more;

    assign w_x_more = (r_rem_x >= STEP_X);
    assign w_y_more = (r_rem_y >= STEP_Y);

    // Load offsets on start, then peel one cell per axis per cycle until both remainders fit in a cell.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem_x <= '0;
            r_rem_y <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_rem_x <= i_off_x;
            r_rem_y <= i_off_y;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (w_x_more) begin
                r_rem_x <= r_rem_x - STEP_X;
                r_col   <= r_col + CW'(1);
            end
            if (w_y_more) begin
                r_rem_y <= r_rem_y - STEP_Y;
                r_row   <= r_row + RW'(1);
            end
            if (!w_x_more && !w_y_more) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_col   = r_col;
    assign o_row   = r_row;
    assign o_valid = r_busy && !w_x_more && !w_y_more;

endmodule

// File: rtl/grid_canvas.sv
// Snaps the pointer to a grid cell, paints/erases it (or clears the grid) one pixel per cycle, tracks occupancy.
// Latency: locate <= max(COLS,ROWS)+1 cycles, then CELL_W*CELL_H plots (or the whole region for clear), then done.
// No backpressure: requests are sampled only in IDLE; anything raised while busy is dropped. Optional: GRID_CANVAS_GAP_EN.
module grid_canvas
    import grid_canvas_pkg::*;
#(
    parameter int X0         = DEF_X0,
    parameter int Y0         = DEF_Y0,
    parameter int CELL_W     = DEF_CELL_W,
    parameter int CELL_H     = DEF_CELL_H,
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter logic [COLOR_BITS-1:0] FG_COLOR = COLOR_BITS'(DEF_FG_COLOR),
    parameter logic [COLOR_BITS-1:0] BG_COLOR = COLOR_BITS'(DEF_BG_COLOR),
    localparam int NCELL = COLS * ROWS,
    localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1
)(
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [8:0]            mouse_x,
    input  logic [8:0]            mouse_y,
    input  logic                  paint,
    input  logic                  erase,
    input  logic                  clear_all,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            vga_x,
    output logic [8:0]            vga_y,
    output logic [COLOR_BITS-1:0] vga_color,
    output logic                  vga_plot,
    input  logic [AW-1:0]         cell_rd_addr,
    output logic                  cell_rd_data
);

    localparam int CW_B = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW_B = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [8:0] X_BASE     = 9'(X0);
    localparam logic [8:0] Y_BASE     = 9'(Y0);
    localparam logic [9:0] X_LO       = 10'(X0);
    localparam logic [9:0] X_HI       = 10'(X0 + COLS * CELL_W);
    localparam logic [9:0] Y_LO       = 10'(Y0);
    localparam logic [9:0] Y_HI       = 10'(Y0 + ROWS * CELL_H);
    localparam logic [8:0] CELL_LASTX = 9'(CELL_W - 1);
    localparam logic [8:0] CELL_LASTY = 9'(CELL_H - 1);
    localparam logic [8:0] REG_LASTX  = 9'(COLS * CELL_W - 1);
    localparam logic [8:0] REG_LASTY  = 9'(ROWS * CELL_H - 1);

    state_t                r_state, w_state_n;
    logic [8:0]            r_px, r_py, w_px_n, w_py_n;
    logic [8:0]            r_bx, r_by, w_bx_n, w_by_n;
    logic [AW-1:0]         r_cell, w_cell_n;
    logic                  r_erase, w_erase_n;
    logic [NCELL-1:0]      r_bitmap;

    logic                  r_busy, r_done, r_plot;
    logic [8:0]            r_vga_x, r_vga_y;
    logic [COLOR_BITS-1:0] r_color;
    logic                  w_busy_n, w_done_n, w_plot_n;
    logic [8:0]            w_x_n, w_y_n;
    logic [COLOR_BITS-1:0] w_color_n;

    logic                  w_in_region;
    logic                  w_loc_start;
    logic                  w_bm_wr;
    logic                  w_bm_clr;
    logic [8:0]            w_off_x, w_off_y;
    logic [CW_B-1:0]       w_loc_col;
    logic [RW_B-1:0]       w_loc_row;
    logic                  w_loc_valid;
    logic [AW-1:0]         w_loc_idx;
    logic [8:0]            w_loc_bx, w_loc_by;

    assign w_in_region = ({1'b0, mouse_x} >= X_LO) && ({1'b0, mouse_x} < X_HI) &&
                         ({1'b0, mouse_y} >= Y_LO) && ({1'b0, mouse_y} < Y_HI);
    assign w_off_x     = mouse_x - X_BASE;
    assign w_off_y     = mouse_y - Y_BASE;

    cell_locator #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H),
        .CW     (CW_B),
        .RW     (RW_B)
    ) u_locator (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_start (w_loc_start),
        .i_off_x (w_off_x),
        .i_off_y (w_off_y),
        .o_col   (w_loc_col),
        .o_row   (w_loc_row),
        .o_valid (w_loc_valid)
    );

    assign w_loc_idx = AW'(w_loc_row) * AW'(COLS) + AW'(w_loc_col);
    assign w_loc_bx  = X_BASE + 9'(w_loc_col) * 9'(CELL_W);
    assign w_loc_by  = Y_BASE + 9'(w_loc_row) * 9'(CELL_H);

    // Next state, next pixel counters and next registered outputs; the outputs are
    // computed one step ahead so vga_plot lines up exactly with FILL/CLEAR.
    always_comb begin
        w_state_n   = r_state;
        w_px_n      = r_px;
        w_py_n      = r_py;
        w_bx_n      = r_bx;
        w_by_n      = r_by;
        w_cell_n    = r_cell;
        w_erase_n   = r_erase;
        w_plot_n    = 1'b0;
        w_done_n    = 1'b0;
        w_x_n       = r_vga_x;
        w_y_n       = r_vga_y;
        w_color_n   = r_color;
        w_loc_start = 1'b0;
        w_bm_wr     = 1'b0;
        w_bm_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_all) begin
                    w_state_n = S_CLEAR;
                    w_px_n    = '0;
                    w_py_n    = '0;
                    w_plot_n  = 1'b1;
                    w_x_n     = X_BASE;
                    w_y_n     = Y_BASE;
                    w_color_n = BG_COLOR;
                end else if ((erase || paint) && w_in_region) begin
                    w_state_n   = S_LOCATE;
                    w_erase_n   = erase;
                    w_loc_start = 1'b1;
                end
            end
            S_LOCATE: begin
                if (w_loc_valid) begin
                    w_cell_n = w_loc_idx;
                    if (r_bitmap[w_loc_idx] == !r_erase) begin
                        // Cell already holds the requested value: skip drawing.
                        w_state_n = S_FINISH;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_FILL;
                        w_px_n    = '0;
                        w_py_n    = '0;
                        w_bx_n    = w_loc_bx;
                        w_by_n    = w_loc_by;
                        w_plot_n  = 1'b1;
                        w_x_n     = w_loc_bx;
                        w_y_n     = w_loc_by;
                        w_color_n = r_erase ? BG_COLOR : FG_COLOR;
                    end
                end
            end
            S_FILL: begin
                if (r_px == CELL_LASTX && r_py == CELL_LASTY) begin
                    w_state_n = S_FINISH;
                    w_done_n  = 1'b1;
                    w_bm_wr   = 1'b1;
                end else begin
                    if (r_px == CELL_LASTX) begin
                        w_px_n = '0;
                        w_py_n = r_py + 9'd1;
                    end else begin
                        w_px_n = r_px + 9'd1;
                    end
                    w_plot_n  = 1'b1;
                    w_x_n     = r_bx + w_px_n;
                    w_y_n     = r_by + w_py_n;
                    w_color_n = r_erase ? BG_COLOR : FG_COLOR;
`ifdef GRID_CANVAS_GAP_EN
                    if (w_px_n == CELL_LASTX || w_py_n == CELL_LASTY) begin
                        w_color_n = BG_COLOR;
                    end
`endif
                end
            end
            S_CLEAR: begin
                if (r_px == REG_LASTX && r_py == REG_LASTY) begin
                    w_state_n = S_FINISH;
                    w_done_n  = 1'b1;
                    w_bm_clr  = 1'b1;
                end else begin
                    if (r_px == REG_LASTX) begin
                        w_px_n = '0;
                        w_py_n = r_py + 9'd1;
                    end else begin
                        w_px_n = r_px + 9'd1;
                    end
                    w_plot_n  = 1'b1;
                    w_x_n     = X_BASE + w_px_n;
                    w_y_n     = Y_BASE + w_py_n;
                    w_color_n = BG_COLOR;
                end
            end
            S_FINISH: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
        w_busy_n = (w_state_n != S_IDLE);
    end

    // State register together with the pixel walk and the latched request context.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_px    <= '0;
            r_py    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
            r_cell  <= '0;
            r_erase <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_px    <= w_px_n;
            r_py    <= w_py_n;
            r_bx    <= w_bx_n;
            r_by    <= w_by_n;
            r_cell  <= w_cell_n;
            r_erase <= w_erase_n;
        end
    end

    // Registered VGA strobe/pixel and handshake outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_plot  <= 1'b0;
            r_vga_x <= '0;
            r_vga_y <= '0;
            r_color <= '0;
        end else begin
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_plot  <= w_plot_n;
            r_vga_x <= w_x_n;
            r_vga_y <= w_y_n;
            r_color <= w_color_n;
        end
    end

    // Occupancy bitmap: updated on the final plot so the new value is readable during FINISH.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bitmap <= '0;
        end else if (w_bm_clr) begin
            r_bitmap <= '0;
        end else if (w_bm_wr) begin
            r_bitmap[r_cell] <= !r_erase;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign vga_plot     = r_plot;
    assign vga_x        = r_vga_x;
    assign vga_y        = r_vga_y;
    assign vga_color    = r_color;
    assign cell_rd_data = r_bitmap[cell_rd_addr];

endmodule

// File: tb/tb_grid_canvas.sv
// Directed plus randomized bench for grid_canvas against a division-based cell/pixel model.
// Plots, done pulses and busy are recorded on the falling edge and compared per request.
// Also covers duplicate suppression, out-of-region requests, clear priority and reset abort.
module tb_grid_canvas;

    localparam int X0   = 88;
    localparam int Y0   = 37;
    localparam int CW   = 10;
    localparam int CH   = 13;
    localparam int COLS = 14;
    localparam int ROWS = 14;
    localparam int NC   = COLS * ROWS;
    localparam logic [14:0] FG = 15'h7FFF;
    localparam logic [14:0] BG = 15'h0000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [8:0]  mouse_x, mouse_y;
    logic        paint, erase, clear_all;
    logic        busy, done, vga_plot;
    logic [8:0]  vga_x, vga_y;
    logic [14:0] vga_color;
    logic [7:0]  cell_rd_addr;
    logic        cell_rd_data;

    grid_canvas dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .paint        (paint),
        .erase        (erase),
        .clear_all    (clear_all),
        .busy         (busy),
        .done         (done),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_color    (vga_color),
        .vga_plot     (vga_plot),
        .cell_rd_addr (cell_rd_addr),
        .cell_rd_data (cell_rd_data)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] cap_q[$];
    logic [32:0] exp_q[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic        rd_at_done = 1'b0;
    bit          model[NC];

    always @(negedge CLOCK_50) begin
        if (vga_plot === 1'b1) cap_q.push_back({vga_x, vga_y, vga_color});
        if (done === 1'b1) begin
            done_cnt   = done_cnt + 1;
            rd_at_done = cell_rd_data;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_grid(input int mx, input int my);
        return mx >= X0 && mx < X0 + COLS * CW && my >= Y0 && my < Y0 + ROWS * CH;
    endfunction

    function automatic int cell_of(input int mx, input int my);
        if (!in_grid(mx, my)) return 5;
        return ((my - Y0) / CH) * COLS + (mx - X0) / CW;
    endfunction

    // Reference: builds the expected plot list and updates the model bitmap.
    task automatic model_req(input bit p, input bit e, input bit c, input int mx, input int my,
                             output int exp_done);
        int idx;
        bit tgt;
        logic [14:0] col;
        exp_q.delete();
        exp_done = 0;
        if (c) begin
            for (int y = 0; y < ROWS * CH; y++)
                for (int x = 0; x < COLS * CW; x++)
                    exp_q.push_back({9'(X0 + x), 9'(Y0 + y), BG});
            for (int a = 0; a < NC; a++) model[a] = 1'b0;
            exp_done = 1;
            return;
        end
        if (!(p || e) || !in_grid(mx, my)) return;
        exp_done = 1;
        idx = cell_of(mx, my);
        tgt = e ? 1'b0 : 1'b1;
        if (model[idx] == tgt) return;
        for (int y = 0; y < CH; y++)
            for (int x = 0; x < CW; x++) begin
                col = e ? BG : FG;
`ifdef GRID_CANVAS_GAP_EN
                if (x == CW - 1 || y == CH - 1) col = BG;
`endif
                exp_q.push_back({9'(X0 + ((mx - X0) / CW) * CW + x),
                                 9'(Y0 + ((my - Y0) / CH) * CH + y), col});
            end
        model[idx] = tgt;
    endtask

    task automatic check_bitmap(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < NC; a++) begin
            cell_rd_addr = 8'(a);
            #1;
            if (cell_rd_data !== logic'(model[a])) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_req(input string tag, input bit p, input bit e, input bit c,
                           input int mx, input int my, input bit noise);
        int d0, c0, b0, exp_done, bad, n, budget, watch;
        watch = cell_of(mx, my);
        model_req(p, e, c, mx, my, exp_done);
        d0 = done_cnt;
        c0 = cap_q.size();
        b0 = busy_cnt;
        @(negedge CLOCK_50);
        cell_rd_addr = 8'(watch);
        mouse_x = 9'(mx); mouse_y = 9'(my);
        paint = p; erase = e; clear_all = c;
        @(negedge CLOCK_50);
        paint = 1'b0; erase = 1'b0; clear_all = 1'b0;
        if (noise) begin
            @(negedge CLOCK_50);
            if (busy) begin
                clear_all = 1'b1; erase = 1'b1;
                @(negedge CLOCK_50);
                clear_all = 1'b0; erase = 1'b0;
            end
        end
        budget = exp_done ? 30000 : 40;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge CLOCK_50);
        repeat (3) @(negedge CLOCK_50);
        n = cap_q.size() - c0;
        check({tag, " done pulses"}, done_cnt - d0, exp_done);
        check({tag, " plot count"}, n, exp_q.size());
        bad = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (cap_q[c0 + i] !== exp_q[i]) bad++;
        check({tag, " plot content errors"}, bad, 0);
        check({tag, " busy seen"}, (busy_cnt != b0) ? 1 : 0, exp_done);
        check({tag, " busy idle"}, busy, 0);
        if (exp_done) check({tag, " bit at done"}, rd_at_done, model[watch]);
        check_bitmap({tag, " bitmap"});
    endtask

    initial begin
        int c0, c1, n, mx, my;
        bit p, e;
        reset = 1'b1;
        mouse_x = '0; mouse_y = '0;
        paint = 1'b0; erase = 1'b0; clear_all = 1'b0;
        cell_rd_addr = '0;
        for (int a = 0; a < NC; a++) model[a] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset plot", vga_plot, 0);
        check("reset vga_x", vga_x, 0);
        check("reset vga_y", vga_y, 0);
        check("reset color", vga_color, 0);
        reset = 1'b0;
        check_bitmap("reset bitmap");

        run_req("paint 88,37", 1, 0, 0, 88, 37, 0);
        run_req("repeat paint 95,40", 1, 0, 0, 95, 40, 0);
        run_req("paint 227,218", 1, 0, 0, 227, 218, 0);
        run_req("erase 227,218", 0, 1, 0, 227, 218, 0);
        run_req("paint 87,37", 1, 0, 0, 87, 37, 0);
        run_req("paint 88,219", 1, 0, 0, 88, 219, 0);
        run_req("paint 227,37", 1, 0, 0, 227, 37, 0);
        run_req("erase+paint 120,60", 1, 1, 0, 120, 60, 0);
        run_req("paint 150,150 noisy", 1, 0, 0, 150, 150, 1);

        for (int k = 0; k < 14; k++) begin
            p = 1'($urandom_range(0, 1));
            e = !p || ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) != 0) begin
                mx = $urandom_range(88, 117); my = $urandom_range(37, 75);
            end else begin
                mx = $urandom_range(80, 235); my = $urandom_range(30, 225);
            end
            run_req($sformatf("rand%0d", k), p, e, 0, mx, my, 1'($urandom_range(0, 1)));
        end

        run_req("pre-clear paint 200,100", 1, 0, 0, 200, 100, 0);
        run_req("pre-clear paint 100,200", 1, 0, 0, 100, 200, 0);
        run_req("clear_all+paint", 1, 0, 1, 100, 200, 0);

        c0 = cap_q.size();
        @(negedge CLOCK_50);
        mouse_x = 9'd150; mouse_y = 9'd100; paint = 1'b1;
        @(negedge CLOCK_50);
        paint = 1'b0;
        for (int i = 0; i < 400 && (cap_q.size() - c0) < 50; i++) @(negedge CLOCK_50);
        n = cap_q.size() - c0;
        check("abort reached 50 plots", (n >= 50 && n < CW * CH) ? 1 : 0, 1);
        reset = 1'b1;
        #1;
        check("abort plot low", vga_plot, 0);
        check("abort busy low", busy, 0);
        check("abort done low", done, 0);
        for (int a = 0; a < NC; a++) model[a] = 1'b0;
        c1 = cap_q.size();
        repeat (3) @(negedge CLOCK_50);
        check("abort no plots in reset", cap_q.size() - c1, 0);
        reset = 1'b0;
        check_bitmap("abort bitmap");
        run_req("post-abort paint 150,100", 1, 0, 0, 150, 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
